sram_access_arbiter: RTL and testbench

- Shares the single-port-pair SRAM (one read port, one write port) between three requesters: 0 = VGA readout, 1 = upsampler, 2 = YUV-to-RGB conversion.
- Replaces fixed phase muxing, so the stages can overlap.
- Uses registered grants and burst-limited ownership. Requester 0 has fixed priority; requesters 1 and 2 are served round-robin.
- Routes read-valid strobes back to the requester that issued each read, after the SRAM read latency.

---
 rtl/sram_access_arbiter_if.sv | 15 +
 rtl/sram_access_arbiter.sv | 90 +++++++++
 tb/tb_sram_access_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_arbiter_if.sv
// sram_access_arbiter_if: requester-side bus of the SRAM access arbiter
interface sram_access_arbiter_if #(
  parameter int AW = 18,
  parameter int DW = 16
);
  logic [2:0]      req;
  logic [2:0]      we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt;
  logic [2:0]      rvalid;
  logic [DW-1:0]   rdata;
  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: shares one SRAM read/write port pair between three requesters
module sram_access_arbiter #(
  parameter int AW         = 18,
  parameter int DW         = 16,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_access_arbiter_if.slave req_if,
  output logic [AW-1:0]        sram_raddr_o,
  input  logic [DW-1:0]        sram_rdata_i,
  output logic [AW-1:0]        sram_waddr_o,
  output logic [DW-1:0]        sram_wdata_o,
  output logic                 sram_wr_enable_o
);
  localparam int CW = $clog2(MAX_BURST);
  typedef enum logic {IDLE, GRANT} state_e;
  state_e state_q, state_d;
  logic [1:0] owner_q, owner_d, rr_pick, winner;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rr_q, rr_d, starve_q, starve_d;
  logic [2:0] gnt_q, gnt_d;
  logic [AW-1:0] raddr_q, own_addr;
  logic [DW-1:0] own_wdata;
  logic [RD_LATENCY-1:0][2:0] pipe_q;
  logic own_req, own_we, access, rd_access, last;
  assign own_req   = req_if.req[owner_q];
  assign own_we    = req_if.we[owner_q];
  assign own_addr  = req_if.addr[owner_q*AW +: AW];
  assign own_wdata = req_if.wdata[owner_q*DW +: DW];
  assign access    = state_q == GRANT && gnt_q[owner_q] && own_req;
  assign rd_access = access && !own_we;
  assign last      = cnt_q == CW'(MAX_BURST - 1);
  // rr_q=0 favours requester 1, rr_q=1 favours requester 2
  assign rr_pick = (rr_q ? (req_if.req[2] || !req_if.req[1]) : !req_if.req[1]) ? 2'd2 : 2'd1;
  assign winner  = (req_if.req[0] && !(starve_q && |req_if.req[2:1])) ? 2'd0 : rr_pick;
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    starve_d = starve_q;
    gnt_d    = gnt_q;
    if (state_q == IDLE) begin
      if (|req_if.req) begin
        state_d  = GRANT;
        owner_d  = winner;
        cnt_d    = '0;
        gnt_d    = 3'b001 << winner;
        starve_d = 1'b0;
        rr_d     = winner == 2'd0 ? rr_q : winner == 2'd1;
      end
    end else if (!own_req || last) begin
      state_d  = IDLE;
      gnt_d    = '0;
      starve_d = own_req && owner_q == 2'd0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      cnt_q    <= '0;
      rr_q     <= 1'b0;
      starve_q <= 1'b0;
      gnt_q    <= '0;
      raddr_q  <= '0;
      pipe_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      starve_q <= starve_d;
      gnt_q    <= gnt_d;
      raddr_q  <= sram_raddr_o;
      pipe_q   <= (3*RD_LATENCY)'({pipe_q, rd_access ? gnt_q : 3'b000});
    end
  end
  assign sram_wr_enable_o = access && own_we;
  assign sram_waddr_o     = sram_wr_enable_o ? own_addr : '0;
  assign sram_wdata_o     = sram_wr_enable_o ? own_wdata : '0;
  assign sram_raddr_o     = rd_access ? own_addr : raddr_q;
  assign req_if.gnt       = gnt_q;
  assign req_if.rvalid    = pipe_q[RD_LATENCY-1];
  assign req_if.rdata     = sram_rdata_i;
endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter: directed checks on two arbiters (read latency 1 and 3) fed the same stimulus
module tb_sram_access_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;
  logic clk, rst;
  logic [2:0] req, we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [DW-1:0] srd;
  logic [AW-1:0] raddr_a, waddr_a, raddr_b, waddr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic wr_a, wr_b;
  int n_cmp = 0;
  int n_bad = 0;
  int ord[6] = '{0, 1, 0, 2, 0, 1};
  sram_access_arbiter_if #(.AW(AW), .DW(DW)) ifa ();
  sram_access_arbiter_if #(.AW(AW), .DW(DW)) ifb ();
  assign ifa.req = req;
  assign ifa.we = we;
  assign ifa.addr = addr;
  assign ifa.wdata = wdata;
  assign ifb.req = req;
  assign ifb.we = we;
  assign ifb.addr = addr;
  assign ifb.wdata = wdata;
  sram_access_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(1), .MAX_BURST(4)) dut_a (
    .clk(clk), .reset(rst), .req_if(ifa.slave),
    .sram_raddr_o(raddr_a), .sram_rdata_i(srd), .sram_waddr_o(waddr_a),
    .sram_wdata_o(wdata_a), .sram_wr_enable_o(wr_a)
  );
  sram_access_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(3), .MAX_BURST(4)) dut_b (
    .clk(clk), .reset(rst), .req_if(ifb.slave),
    .sram_raddr_o(raddr_b), .sram_rdata_i(srd), .sram_waddr_o(waddr_b),
    .sram_wdata_o(wdata_b), .sram_wr_enable_o(wr_b)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    we = '0;
    addr = '0;
    wdata = '0;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    clk = 1'b0;
    rst = 1'b1;
    req = '0;
    we = '0;
    addr = '0;
    wdata = '0;
    srd = 16'h1234;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_gnt", ifa.gnt, 0);
    chk("rst_rvalid", ifa.rvalid, 0);
    chk("rst_wr", wr_a, 0);
    chk("rst_raddr", raddr_a, 0);
    chk("rst_waddr", waddr_a, 0);
    chk("rst_wdata", wdata_a, 0);
    chk("rdata_pass", ifa.rdata, 16'h1234);
    // single requester 1 reading four consecutive addresses
    req = 3'b010;
    addr[AW +: AW] = AW'(32'h10);
    #1;
    chk("t1_gnt_lat", ifa.gnt, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      addr[AW +: AW] = AW'(32'h10 + i);
      #1;
      chk("t1_gnt", ifa.gnt, 3'b010);
      chk("t1_raddr", raddr_a, 32'h10 + i);
      chk("t1_rvalid", ifa.rvalid, i == 0 ? 0 : 3'b010);
      if (i == 3) chk("t1_rvalid_lat3", ifb.rvalid, 3'b010);
    end
    tick();
    req = '0;
    addr = '0;
    #1;
    chk("t1_expire_gnt", ifa.gnt, 0);
    chk("t1_last_rvalid", ifa.rvalid, 3'b010);
    chk("t1_raddr_hold", raddr_a, 32'h13);
    tick();
    #1;
    chk("t1_rvalid_done", ifa.rvalid, 0);
    do_reset();
    // all three requesting: 0 then round-robin 1/2, four accesses per grant
    req = 3'b111;
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 5; j++) begin
        tick();
        #1;
        chk("t2_gnt", ifa.gnt, j < 4 ? (32'd1 << ord[k]) : 32'd0);
      end
    do_reset();
    // requester 2 writes one word while requester 1 waits
    req = 3'b100;
    we = 3'b100;
    addr = {18'h1C200, 18'h00777, 18'h00000};
    wdata = {16'hBEEF, 16'h1111, 16'h0000};
    #1;
    chk("t3_wr_pre", wr_a, 0);
    tick();
    req = 3'b110;
    #1;
    chk("t3_gnt2", ifa.gnt, 3'b100);
    chk("t3_wr", wr_a, 1);
    chk("t3_waddr", waddr_a, 18'h1C200);
    chk("t3_wdata", wdata_a, 16'hBEEF);
    tick();
    req = 3'b010;
    we = '0;
    #1;
    chk("t3_no_preempt", ifa.gnt, 3'b100);
    chk("t3_wr_once", wr_a, 0);
    tick();
    #1;
    chk("t3_dead", ifa.gnt, 0);
    tick();
    #1;
    chk("t3_gnt1", ifa.gnt, 3'b010);
    chk("t3_wr_after", wr_a, 0);
    do_reset();
    // outstanding read from owner 1 survives a grant change
    req = 3'b010;
    addr[AW +: AW] = AW'(32'h55);
    tick();
    req = 3'b011;
    #1;
    chk("t4_gnt1", ifb.gnt, 3'b010);
    chk("t4_raddr", raddr_b, 32'h55);
    tick();
    req = 3'b001;
    #1;
    chk("t4_gnt1_drop", ifb.gnt, 3'b010);
    chk("t4_rvalid_lat1", ifa.rvalid, 3'b010);
    chk("t4_rvalid_early", ifb.rvalid, 0);
    tick();
    #1;
    chk("t4_dead", ifb.gnt, 0);
    chk("t4_rvalid_wait", ifb.rvalid, 0);
    tick();
    #1;
    chk("t4_gnt0", ifb.gnt, 3'b001);
    chk("t4_rvalid_routed", ifb.rvalid, 3'b010);
    tick();
    #1;
    chk("t4_rvalid_once", ifb.rvalid, 0);
    do_reset();
    // reset during a requester-2 burst with reads in flight
    req = 3'b100;
    tick();
    #1;
    chk("t5_gnt2", ifb.gnt, 3'b100);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 3'b110;
    #1;
    chk("t5_gnt", ifb.gnt, 0);
    chk("t5_wr", wr_b, 0);
    chk("t5_rvalid_b", ifb.rvalid, 0);
    chk("t5_rvalid_a", ifa.rvalid, 0);
    chk("t5_raddr", raddr_b, 0);
    tick();
    #1;
    chk("t5_gnt1", ifb.gnt, 3'b010);
    chk("t5_rvalid_b2", ifb.rvalid, 0);
    tick();
    #1;
    chk("t5_rvalid_b3", ifb.rvalid, 0);
    do_reset();
    // requester 0 drops req on its burst-expiry cycle: treated as a drop
    req = 3'b011;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("t6_gnt0", ifa.gnt, 3'b001);
    end
    tick();
    req = 3'b010;
    #1;
    chk("t6_gnt0_last", ifa.gnt, 3'b001);
    tick();
    req = 3'b011;
    #1;
    chk("t6_dead", ifa.gnt, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk("t6_regrant0", ifa.gnt, 3'b001);
    end
    tick();
    #1;
    chk("t6_expire", ifa.gnt, 0);
    tick();
    #1;
    chk("t6_guard", ifa.gnt, 3'b010);
    req = '0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
